// File: rtl/mm_mem_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mm_mem_scheduler: shares one memory port between operand line fetches for    |
// | matrix_multiplier and row-major writeback of its result FIFO into C.         |
// | Optional: define MM_SCHED_PERF_EN for stall-cycle / writeback counters.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module mm_mem_scheduler #(
  parameter int N           = 8,
  parameter int M           = 10,
  parameter int P           = 9,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 33,
  parameter int ADDR_WIDTH  = 12,
  parameter int A_BASE      = 0,
  parameter int B_BASE      = 64,
  parameter int C_BASE      = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      fetch_row,
  input  logic                      fetch_col,
  input  logic [$clog2(N)-1:0]      n,
  input  logic [$clog2(M)-1:0]      m,
  output logic                      data_stall,
  output logic                      fetch_stall,
  output logic [P*DATA_WIDTH-1:0]   line_out,
  input  logic                      fifo_empty,
  input  logic                      fifo_full,
  input  logic [ACCUM_WIDTH-1:0]    fifo_head,
  output logic                      pop_fifo,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [ACCUM_WIDTH-1:0]    mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [P*DATA_WIDTH-1:0]   mem_rdata,
  output logic                      wb_done
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_stall_cyc,
  output logic [31:0]               perf_wb_cnt
`endif
);

  localparam int NW = $clog2(N);
  localparam int MW = $clog2(M);
  localparam logic [ADDR_WIDTH-1:0] c_a_base = ADDR_WIDTH'(A_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_b_base = ADDR_WIDTH'(B_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_c_base = ADDR_WIDTH'(C_BASE);
  localparam logic [NW-1:0]         c_n_last = NW'(N - 1);
  localparam logic [MW-1:0]         c_m_last = MW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR_REQ  = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_pend_row, r_pend_col;
  logic [NW-1:0]           r_n_lat;
  logic [MW-1:0]           r_m_lat;
  logic                    r_rd_col;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [P*DATA_WIDTH-1:0] r_line;
  logic [NW-1:0]           r_wr_n;
  logic [MW-1:0]           r_wr_m;
  logic                    r_wb_done;
  logic                    r_data_stall;

  logic                    w_go_col;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic                    w_rd_gnt, w_wr_gnt;
  logic                    w_pend_row_nxt, w_pend_col_nxt;
  logic                    w_stall_nxt;

  assign w_wr_addr = c_c_base + ADDR_WIDTH'(r_wr_n) * ADDR_WIDTH'(M) + ADDR_WIDTH'(r_wr_m);
  assign w_rd_gnt  = (r_state == S_RD_REQ) & mem_gnt;
  assign w_wr_gnt  = (r_state == S_WR_REQ) & mem_gnt;

  // A new pulse of the type being granted this cycle keeps its flag set.
  assign w_pend_row_nxt = fetch_row | (r_pend_row & ~(w_rd_gnt & ~r_rd_col));
  assign w_pend_col_nxt = fetch_col | (r_pend_col & ~(w_rd_gnt &  r_rd_col));

  always_comb begin
    w_state_nxt = r_state;
    w_go_col    = 1'b0;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (fifo_full & ~fifo_empty & ~r_wb_done) begin
          w_state_nxt = S_WR_REQ;
          w_addr_nxt  = w_wr_addr;
        end else if (r_pend_row) begin
          w_state_nxt = S_RD_REQ;
          w_addr_nxt  = c_a_base + ADDR_WIDTH'(r_n_lat);
        end else if (r_pend_col) begin
          w_state_nxt = S_RD_REQ;
          w_go_col    = 1'b1;
          w_addr_nxt  = c_b_base + ADDR_WIDTH'(r_m_lat);
        end else if (~fifo_empty & ~r_wb_done) begin
          w_state_nxt = S_WR_REQ;
          w_addr_nxt  = w_wr_addr;
        end
      end
      S_RD_REQ:  if (mem_gnt)    w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid) w_state_nxt = S_IDLE;
      S_WR_REQ:  if (mem_gnt)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall_nxt = w_pend_row_nxt | w_pend_col_nxt |
                       (w_state_nxt == S_RD_REQ) | (w_state_nxt == S_RD_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend_row   <= 1'b0;
      r_pend_col   <= 1'b0;
      r_n_lat      <= '0;
      r_m_lat      <= '0;
      r_rd_col     <= 1'b0;
      r_addr       <= '0;
      r_line       <= '0;
      r_wr_n       <= '0;
      r_wr_m       <= '0;
      r_wb_done    <= 1'b0;
      r_data_stall <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_row   <= w_pend_row_nxt;
      r_pend_col   <= w_pend_col_nxt;
      r_data_stall <= w_stall_nxt;
      if (fetch_row) r_n_lat <= n;
      if (fetch_col) r_m_lat <= m;
      // Address is frozen on leaving IDLE so late index updates cannot disturb a waiting request.
      if (r_state == S_IDLE) begin
        r_addr   <= w_addr_nxt;
        r_rd_col <= w_go_col;
      end
      if ((r_state == S_RD_WAIT) && mem_rvalid) r_line <= mem_rdata;
      if (start) begin
        r_wr_n    <= '0;
        r_wr_m    <= '0;
        r_wb_done <= 1'b0;
      end else if (w_wr_gnt) begin
        if (r_wr_m == c_m_last) begin
          r_wr_m <= '0;
          if (r_wr_n == c_n_last) begin
            r_wr_n    <= '0;
            r_wb_done <= 1'b1;
          end else begin
            r_wr_n <= r_wr_n + NW'(1);
          end
        end else begin
          r_wr_m <= r_wr_m + MW'(1);
        end
      end
    end
  end

  assign mem_req     = (r_state == S_RD_REQ) | (r_state == S_WR_REQ);
  assign mem_we      = (r_state == S_WR_REQ);
  assign mem_addr    = r_addr;
  assign mem_wdata   = fifo_head;
  assign pop_fifo    = w_wr_gnt & ~rst;
  assign fetch_stall = r_pend_row | r_pend_col | (r_state != S_IDLE);
  assign data_stall  = r_data_stall;
  assign line_out    = r_line;
  assign wb_done     = r_wb_done;

`ifdef MM_SCHED_PERF_EN
  logic [31:0] r_perf_stall_cyc;
  logic [31:0] r_perf_wb_cnt;

  always_ff @(posedge clk) begin
    if (rst | start) begin
      r_perf_stall_cyc <= '0;
      r_perf_wb_cnt    <= '0;
    end else begin
      if (r_data_stall & ~(&r_perf_stall_cyc)) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (w_wr_gnt & ~(&r_perf_wb_cnt))        r_perf_wb_cnt    <= r_perf_wb_cnt + 32'd1;
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_wb_cnt    = r_perf_wb_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mm_mem_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mm_mem_scheduler: directed stimulus with a memory-transaction scoreboard. |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_mm_mem_scheduler;
  localparam int N = 8, M = 10, P = 9, DW = 16, AW = 33, ADW = 12;
  localparam int LW = P * DW;

  logic clk, rst, start, fetch_row, fetch_col;
  logic [$clog2(N)-1:0] n;
  logic [$clog2(M)-1:0] m;
  logic data_stall, fetch_stall, pop_fifo, mem_req, mem_we, wb_done;
  logic fifo_empty, fifo_full, mem_gnt, mem_rvalid;
  logic [LW-1:0]  line_out, mem_rdata;
  logic [AW-1:0]  fifo_head, mem_wdata;
  logic [ADW-1:0] mem_addr;
`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_stall_cyc, perf_wb_cnt;
`endif

  mm_mem_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .fetch_row(fetch_row), .fetch_col(fetch_col),
    .n(n), .m(m), .data_stall(data_stall), .fetch_stall(fetch_stall), .line_out(line_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_head(fifo_head), .pop_fifo(pop_fifo),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_done(wb_done)
`ifdef MM_SCHED_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_wb_cnt(perf_wb_cnt)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [ADW-1:0] addr;
    logic [AW-1:0]  wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   gnt_lat = 0, rv_lat = 1, wait_cnt = 0, rv_cnt = 0, rv_addr = 0;
  int   fifo_cnt = 0, fifo_idx = 0, req_wait_cyc = 0;
  logic last_gnt_wr = 1'b0, force_full = 1'b0;

  function automatic logic [AW-1:0] head_val(input int i);
    return 33'h1_0000_0000 | 33'(i * 7919 + 5);
  endfunction

  function automatic logic [LW-1:0] pat(input int a);
    logic [LW-1:0] r;
    for (int k = 0; k < P; k++) r[k*DW +: DW] = 16'(a * 256 + k);
    return r;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic we, input int addr, input logic [AW-1:0] wd);
    txn_t t;
    t.we = we; t.addr = ADW'(addr); t.wdata = wd;
    exp_q.push_back(t);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || data_stall || mem_req) && c < budget) begin
      tick();
      c++;
    end
    check(name, LW'(c < budget), LW'(1));
  endtask

  assign fifo_empty = (fifo_cnt == 0);
  assign fifo_full  = force_full;
  assign fifo_head  = head_val(fifo_idx);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory and FIFO model: drives grant/rvalid and consumes the FIFO on granted writes.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (last_gnt_wr && fifo_cnt > 0) begin
        fifo_idx++;
        fifo_cnt--;
      end
      last_gnt_wr = 1'b0;
      mem_rvalid  = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pat(rv_addr);
        end
      end
      mem_gnt = 1'b0;
      if (mem_req && !rst) begin
        if (wait_cnt >= gnt_lat) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (mem_we) last_gnt_wr = 1'b1;
          else begin
            rv_cnt  = rv_lat;
            rv_addr = int'(mem_addr);
          end
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Scoreboard monitor: every presented request must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_req: actual we=%0b addr=%0d required none", mem_we, mem_addr);
          end else begin
            check("req_we", LW'(mem_we), LW'(exp_q[0].we));
            check("req_addr", LW'(mem_addr), LW'(exp_q[0].addr));
            if (exp_q[0].we) check("req_wdata", LW'(mem_wdata), LW'(exp_q[0].wdata));
            if (mem_gnt) begin
              check("pop_on_gnt", LW'(pop_fifo), LW'(exp_q[0].we));
              void'(exp_q.pop_front());
            end else req_wait_cyc++;
          end
        end else if (pop_fifo) begin
          n_cmp++; n_err++;
          $display("FAIL stray_pop: actual pop=1 required 0");
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; fetch_row = 1'b0; fetch_col = 1'b0; n = '0; m = '0;
    repeat (3) tick();
    check("rst_data_stall", LW'(data_stall), LW'(0));
    check("rst_fetch_stall", LW'(fetch_stall), LW'(0));
    check("rst_mem_req", LW'(mem_req), LW'(0));
    check("rst_line_out", line_out, LW'(0));
    check("rst_wb_done", LW'(wb_done), LW'(0));
    check("rst_mem_addr", LW'(mem_addr), LW'(0));
    rst = 1'b0;

    // T1: single row fetch, minimum latency
    push(1'b0, 3, '0);
    n = 3; fetch_row = 1'b1;
    tick(); fetch_row = 1'b0;
    check("t1_stall_t1", LW'(data_stall), LW'(1));
    check("t1_fetch_stall", LW'(fetch_stall), LW'(1));
    tick(); check("t1_stall_t2", LW'(data_stall), LW'(1));
    tick(); check("t1_stall_t3", LW'(data_stall), LW'(1));
    tick(); check("t1_stall_t4", LW'(data_stall), LW'(0));
    check("t1_line", line_out, pat(3));

    // T2: row and col in the same cycle
    push(1'b0, 2, '0);
    push(1'b0, 69, '0);
    n = 2; m = 5; fetch_row = 1'b1; fetch_col = 1'b1;
    tick(); fetch_row = 1'b0; fetch_col = 1'b0;
    for (int c = 0; c < 50 && data_stall; c++) tick();
    check("t2_both_served_at_stall_low", LW'(exp_q.size()), LW'(0));
    check("t2_line_col", line_out, pat(69));
    check("t2_stall_low", LW'(data_stall), LW'(0));

    // T3: full result stream; one extra entry must not be written
    for (int i = 0; i < N * M; i++) push(1'b1, 128 + i, head_val(i));
    fifo_cnt = N * M + 1;
    wait_drain("t3_timeout", 2000);
    repeat (5) tick();
    check("t3_wb_done", LW'(wb_done), LW'(1));
    check("t3_pops", LW'(fifo_idx), LW'(N * M));
    check("t3_leftover", LW'(fifo_cnt), LW'(1));

    // T4: fifo_full beats a pending row fetch; start re-enables writeback
    push(1'b1, 128, head_val(80));
    push(1'b0, 6, '0);
    start = 1'b1; n = 6; fetch_row = 1'b1; force_full = 1'b1;
    tick(); start = 1'b0; fetch_row = 1'b0;
    check("t4_wb_done_cleared", LW'(wb_done), LW'(0));
    wait_drain("t4_timeout", 100);
    force_full = 1'b0;
    check("t4_line", line_out, pat(6));
    check("t4_pops", LW'(fifo_idx), LW'(81));

    // T5: grant withheld for five cycles
    req_wait_cyc = 0;
    gnt_lat = 5;
    push(1'b1, 129, head_val(81));
    fifo_cnt = 1;
    wait_drain("t5_timeout", 100);
    gnt_lat = 0;
    check("t5_wait_cycles", LW'(req_wait_cyc), LW'(5));
    check("t5_single_pop", LW'(fifo_idx), LW'(82));

    // T6: reset while waiting for read data; late rvalid ignored
    rv_lat = 4;
    push(1'b0, 1, '0);
    n = 1; fetch_row = 1'b1;
    tick(); fetch_row = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check("t6_granted", LW'(exp_q.size()), LW'(0));
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("t6_data_stall", LW'(data_stall), LW'(0));
    check("t6_mem_req", LW'(mem_req), LW'(0));
    check("t6_fetch_stall", LW'(fetch_stall), LW'(0));
    check("t6_line_rst", line_out, LW'(0));
    repeat (6) tick();
    check("t6_line_after_rvalid", line_out, LW'(0));
    check("t6_stall_after", LW'(data_stall), LW'(0));
    rv_lat = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
